// File: rtl/signed_adder_pipe_if.sv
// Handshake and data bundle for signed_adder_pipe.
// slave = the adder's view, master = the producer/consumer's view.
interface signed_adder_pipe_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned IN1_WIDTH = 20,
    parameter int unsigned IN2_WIDTH = 32,
    parameter int unsigned OUT_WIDTH = 32
);
    logic                           in_valid;
    logic                           in_ready;
    logic                           sub;
    logic [NUM_LANES*IN1_WIDTH-1:0] a;
    logic [NUM_LANES*IN2_WIDTH-1:0] b;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_LANES*OUT_WIDTH-1:0] out;
    logic [NUM_LANES-1:0]           ovf;
    logic                           ovf_sticky;
    logic                           clear_sticky;

    modport slave (
        input  in_valid, sub, a, b, out_ready, clear_sticky,
        output in_ready, out_valid, out, ovf, ovf_sticky
    );

    modport master (
        output in_valid, sub, a, b, out_ready, clear_sticky,
        input  in_ready, out_valid, out, ovf, ovf_sticky
    );
endinterface

// File: rtl/signed_adder_pipe.sv
// Multi-lane signed add/sub with valid/ready pipeline, per-lane overflow and sticky flag.
// Define SIGNED_ADDER_PIPE_SAT_EN to saturate overflowing lanes instead of wrapping.
module signed_adder_pipe #(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned IN1_WIDTH   = 20,
    parameter int unsigned IN2_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH   = 32,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    signed_adder_pipe_if.slave  bus
);
    localparam int unsigned MAXW = (IN1_WIDTH > IN2_WIDTH) ? IN1_WIDTH : IN2_WIDTH;
    localparam int unsigned W    = MAXW + 1;
    localparam int unsigned DW   = NUM_LANES * OUT_WIDTH;

    localparam logic [OUT_WIDTH-1:0] SAT_MIN = OUT_WIDTH'(1) << (OUT_WIDTH - 1);
    localparam logic [OUT_WIDTH-1:0] SAT_MAX = ~SAT_MIN;

    logic [DW-1:0]        res_c;
    logic [NUM_LANES-1:0] ovf_c;
    logic                 adv_c;

    // Per-lane exact W-bit arithmetic and range check against OUT_WIDTH
    for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
        logic [IN1_WIDTH-1:0] a_l;
        logic [IN2_WIDTH-1:0] b_l;
        logic [W-1:0]         a_x;
        logic [W-1:0]         b_x;
        logic [W-1:0]         sum_l;
        logic [OUT_WIDTH-1:0] lane_res;
        logic                 lane_ovf;

        always_comb begin
            a_l   = bus.a[i*IN1_WIDTH +: IN1_WIDTH];
            b_l   = bus.b[i*IN2_WIDTH +: IN2_WIDTH];
            a_x   = {{(W-IN1_WIDTH){a_l[IN1_WIDTH-1]}}, a_l};
            b_x   = {{(W-IN2_WIDTH){b_l[IN2_WIDTH-1]}}, b_l};
            sum_l = bus.sub ? (a_x - b_x) : (a_x + b_x);
        end

        if (OUT_WIDTH < W) begin : g_narrow
            // Fits iff all bits from the output sign bit upward agree
            logic hi_ok;
            always_comb begin
                hi_ok    = (sum_l[W-1:OUT_WIDTH-1] == '0) || (sum_l[W-1:OUT_WIDTH-1] == '1);
                lane_ovf = ~hi_ok;
`ifdef SIGNED_ADDER_PIPE_SAT_EN
                if (!hi_ok) begin
                    lane_res = sum_l[W-1] ? SAT_MIN : SAT_MAX;
                end else begin
                    lane_res = sum_l[OUT_WIDTH-1:0];
                end
`else
                lane_res = sum_l[OUT_WIDTH-1:0];
`endif
            end
        end else if (OUT_WIDTH == W) begin : g_exact
            always_comb begin
                lane_ovf = 1'b0;
                lane_res = sum_l;
            end
        end else begin : g_wide
            always_comb begin
                lane_ovf = 1'b0;
                lane_res = {{(OUT_WIDTH-W){sum_l[W-1]}}, sum_l};
            end
        end

        assign res_c[i*OUT_WIDTH +: OUT_WIDTH] = lane_res;
        assign ovf_c[i]                        = lane_ovf;
    end

    logic [PIPE_STAGES-1:0] vld_q, vld_d;
    logic [DW-1:0]          dat_q [PIPE_STAGES];
    logic [DW-1:0]          dat_d [PIPE_STAGES];
    logic [NUM_LANES-1:0]   ovf_q [PIPE_STAGES];
    logic [NUM_LANES-1:0]   ovf_d [PIPE_STAGES];
    logic                   sticky_q, sticky_d;

    assign adv_c = bus.out_ready | ~vld_q[PIPE_STAGES-1];

    // Lock-step shift: bubbles travel with the stream, empty stages carry zero data
    always_comb begin
        vld_d = vld_q;
        for (int s = 0; s < int'(PIPE_STAGES); s++) begin
            dat_d[s] = dat_q[s];
            ovf_d[s] = ovf_q[s];
        end
        if (adv_c) begin
            vld_d[0] = bus.in_valid;
            dat_d[0] = bus.in_valid ? res_c : '0;
            ovf_d[0] = bus.in_valid ? ovf_c : '0;
            for (int s = 1; s < int'(PIPE_STAGES); s++) begin
                vld_d[s] = vld_q[s-1];
                dat_d[s] = dat_q[s-1];
                ovf_d[s] = ovf_q[s-1];
            end
        end
    end

    // Set on an overflowing output transfer wins over a same-cycle clear
    always_comb begin
        sticky_d = sticky_q & ~bus.clear_sticky;
        if (vld_q[PIPE_STAGES-1] && bus.out_ready && (ovf_q[PIPE_STAGES-1] != '0)) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q    <= '0;
            sticky_q <= 1'b0;
            for (int s = 0; s < int'(PIPE_STAGES); s++) begin
                dat_q[s] <= '0;
                ovf_q[s] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            sticky_q <= sticky_d;
            for (int s = 0; s < int'(PIPE_STAGES); s++) begin
                dat_q[s] <= dat_d[s];
                ovf_q[s] <= ovf_d[s];
            end
        end
    end

    assign bus.in_ready   = adv_c;
    assign bus.out_valid  = vld_q[PIPE_STAGES-1];
    assign bus.out        = dat_q[PIPE_STAGES-1];
    assign bus.ovf        = ovf_q[PIPE_STAGES-1];
    assign bus.ovf_sticky = sticky_q;

endmodule
